// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage pipeline control path.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } seq_state_t;

    localparam int DEFAULT_REG_ADDR_W = 4;
    localparam int STALL_CNT_W        = 16;

endpackage

// File: rtl/hazard_detector.sv
// Load-use comparator: flags a decode-stage read of a register that the
// load currently in execute has not yet produced.
module hazard_detector
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  hazard
);

    // Register 0 is hardwired, so a load targeting it never blocks a reader.
    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller: buffer load/flush decode, memory-wait freeze,
// stall counting and halt latching.
module pipeline_sequencer
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W  = DEFAULT_REG_ADDR_W,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   pc_src,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    input  logic                   wb_halt,
    output logic                   pc_enable,
    output logic                   load_fetch,
    output logic                   load_decode,
    output logic                   load_execute,
    output logic                   load_memory,
    output logic                   load_writeback,
    output logic                   flush_decode,
    output logic                   flush_execute,
    output logic                   halted,
    output logic                   mem_error,
    output logic [STALL_CNT_W-1:0] stall_count,
    output seq_state_t             state_dbg
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    seq_state_t             state_q, state_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   mem_error_q, mem_error_d;
    logic                   hazard;

    hazard_detector #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (hazard)
    );

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_error_d    = mem_error_q;
        pc_enable      = 1'b0;
        load_fetch     = 1'b0;
        load_decode    = 1'b0;
        load_execute   = 1'b0;
        load_memory    = 1'b0;
        load_writeback = 1'b0;
        flush_decode   = 1'b0;
        flush_execute  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (wb_halt) begin
                    state_d = HALT;
                end else if (mem_req && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    pc_enable      = 1'b1;
                    load_fetch     = 1'b1;
                    load_decode    = 1'b1;
                    load_execute   = 1'b1;
                    load_memory    = 1'b1;
                    load_writeback = 1'b1;
                    // A taken branch squashes the younger stages, so any
                    // load-use hazard it would have caused disappears too.
                    if (pc_src) begin
                        flush_decode  = 1'b1;
                        flush_execute = 1'b1;
                    end else if (hazard) begin
                        pc_enable     = 1'b0;
                        load_fetch    = 1'b0;
                        load_decode   = 1'b0;
                        flush_execute = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    pc_enable      = 1'b1;
                    load_fetch     = 1'b1;
                    load_decode    = 1'b1;
                    load_execute   = 1'b1;
                    load_memory    = 1'b1;
                    load_writeback = 1'b1;
                    state_d        = RUN;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                    mem_error_d = 1'b1;
                    state_d     = HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every frozen or bubbled cycle while executing is a stall; saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (((state_q == RUN) || (state_q == MEM_WAIT)) && !pc_enable &&
            (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign halted      = (state_q == HALT);
    assign mem_error   = mem_error_q;
    assign stall_count = stall_cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed scoreboard bench for pipeline_sequencer.
module tb_pipeline_sequencer;
    import pipeline_pkg::*;

    localparam int W = 28;
    localparam logic [7:0] C_NONE = 8'h00;
    localparam logic [7:0] C_RUN  = 8'hFC;
    localparam logic [7:0] C_BR   = 8'hFF;
    localparam logic [7:0] C_LU   = 8'h1D;

    logic        clk, reset, start;
    logic [3:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, pc_src, mem_req, mem_ready, wb_halt;
    logic        pc_enable, load_fetch, load_decode, load_execute, load_memory, load_writeback;
    logic        flush_decode, flush_execute, halted, mem_error;
    logic [15:0] stall_count;
    seq_state_t  state_dbg;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [W-1:0] got_vec, mon_exp;
    string        mon_nm;
    int           pass_cnt = 0;
    int           total_cnt = 0;

    pipeline_sequencer #(.REG_ADDR_W(4), .MEM_TIMEOUT(15)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .pc_src         (pc_src),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .wb_halt        (wb_halt),
        .pc_enable      (pc_enable),
        .load_fetch     (load_fetch),
        .load_decode    (load_decode),
        .load_execute   (load_execute),
        .load_memory    (load_memory),
        .load_writeback (load_writeback),
        .flush_decode   (flush_decode),
        .flush_execute  (flush_execute),
        .halted         (halted),
        .mem_error      (mem_error),
        .stall_count    (stall_count),
        .state_dbg      (state_dbg)
    );

    assign got_vec = {2'(state_dbg), pc_enable, load_fetch, load_decode, load_execute,
                      load_memory, load_writeback, flush_decode, flush_execute,
                      halted, mem_error, stall_count};

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [W-1:0] g, input logic [W-1:0] e);
        total_cnt++;
        if (g === e) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, g, e);
    endtask

    task automatic zero_inputs();
        start = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        ex_mem_read = 0; pc_src = 0; mem_req = 0; mem_ready = 0; wb_halt = 0;
    endtask

    // Driver: apply one cycle of inputs and queue the expected Mealy response.
    task automatic step(input logic st, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [3:0] rd, input logic mr, input logic br, input logic mq,
                        input logic my, input logic wh, input seq_state_t es,
                        input logic [7:0] ec, input logic eh, input logic ee,
                        input logic [15:0] esc, input string nm);
        @(posedge clk);
        #1;
        start = st; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_mem_read = mr;
        pc_src = br; mem_req = mq; mem_ready = my; wb_halt = wh;
        exp_q.push_back({2'(es), ec, eh, ee, esc});
        name_q.push_back(nm);
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic do_reset(input string nm);
        @(posedge clk);
        #1;
        zero_inputs();
        reset = 1'b1;
        #1;
        check(nm, got_vec, '0);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            check(mon_nm, got_vec, mon_exp);
        end
    end

    // Stimulus
    initial begin
        reset = 1'b1;
        zero_inputs();
        #1;
        check("reset_t0", got_vec, '0);
        step(0,0,0,0,0,0,0,0,0, IDLE, C_NONE,0,0,16'd0, "reset_hold");
        step(0,0,0,0,0,0,0,0,0, IDLE, C_NONE,0,0,16'd0, "reset_hold");
        @(posedge clk);
        #1;
        reset = 1'b0;

        step(1,0,0,0,0,0,0,0,0, IDLE, C_NONE,0,0,16'd0, "idle_start");
        for (int i = 0; i < 10; i++)
            step(0,1,2,3,0,0,0,0,0, RUN, C_RUN,0,0,16'd0, "run_clean");
        step(0,4,3,3,1,0,0,0,0, RUN, C_LU,  0,0,16'd0, "load_use");
        step(0,4,3,3,0,0,0,0,0, RUN, C_RUN, 0,0,16'd1, "after_load_use");
        step(0,0,0,0,1,0,0,0,0, RUN, C_RUN, 0,0,16'd1, "rd_zero");
        step(0,1,2,3,0,0,0,0,0, RUN, C_RUN, 0,0,16'd1, "run_clean2");
        step(0,1,2,3,0,0,1,0,0, RUN, C_NONE,0,0,16'd1, "mem_req");
        step(0,1,2,3,0,0,1,0,0, MEM_WAIT, C_NONE,0,0,16'd2, "mem_wait1");
        step(0,1,2,3,0,0,1,0,0, MEM_WAIT, C_NONE,0,0,16'd3, "mem_wait2");
        step(0,1,2,3,0,0,1,0,0, MEM_WAIT, C_NONE,0,0,16'd4, "mem_wait3");
        step(0,1,2,3,0,0,1,1,0, MEM_WAIT, C_RUN, 0,0,16'd5, "mem_release");
        step(0,1,2,3,0,0,0,0,0, RUN, C_RUN, 0,0,16'd5, "after_release");
        step(0,1,2,3,0,0,1,1,0, RUN, C_RUN, 0,0,16'd5, "mem_ready_same");
        step(0,5,1,5,1,1,0,0,0, RUN, C_BR,  0,0,16'd5, "branch_vs_hazard");
        step(0,1,2,3,0,0,0,0,0, RUN, C_RUN, 0,0,16'd5, "after_branch");
        step(0,1,2,3,0,1,1,0,0, RUN, C_NONE,0,0,16'd5, "freeze_vs_branch");
        step(0,1,2,3,0,1,1,1,0, MEM_WAIT, C_RUN, 0,0,16'd6, "freeze_release");
        step(0,1,2,3,0,1,0,0,0, RUN, C_BR,  0,0,16'd6, "held_branch");
        step(0,1,2,3,0,0,0,0,0, RUN, C_RUN, 0,0,16'd6, "after_held_branch");
        step(0,1,2,3,0,0,1,0,0, RUN, C_NONE,0,0,16'd6, "mem_req2");
        step(0,1,2,3,0,0,1,0,0, MEM_WAIT, C_NONE,0,0,16'd7, "mem_wait_pre_reset");
        do_reset("reset_mid_wait");

        step(1,0,0,0,0,0,0,0,0, IDLE, C_NONE,0,0,16'd0, "restart");
        step(0,1,2,3,0,0,1,0,0, RUN, C_NONE,0,0,16'd0, "mem_req3");
        for (int k = 1; k <= 15; k++)
            step(0,1,2,3,0,0,1,0,0, MEM_WAIT, C_NONE,0,0,16'(k), "timeout_wait");
        for (int i = 0; i < 3; i++)
            step(1,5,5,5,1,1,1,1,1, HALT, C_NONE,1,1,16'd16, "halt_ignore");
        do_reset("reset_from_halt");

        step(1,0,0,0,0,0,0,0,0, IDLE, C_NONE,0,0,16'd0, "restart2");
        step(0,1,2,3,0,0,0,0,0, RUN, C_RUN, 0,0,16'd0, "run_before_halt");
        step(0,1,2,3,0,1,0,0,1, RUN, C_NONE,0,0,16'd0, "wb_halt");
        step(0,0,0,0,0,0,0,0,0, HALT, C_NONE,1,0,16'd1, "halted");

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
